serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_if.sv | 26 ++
 rtl/serial_adder.sv | 128 ++++++++++++
 tb/tb_serial_adder.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// Handshake/operand/result bundle for serial_adder.
//   master: drives start, a, b, cin; observes busy, done, sum, cout, ovf
//   slave : the adder side of the same signals
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice plus carry flop, LSB first,
// WIDTH clocks per addition. Results are held until the next completion.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : serial_adder_if.slave (start/a/b/cin in, busy/done/sum/cout/ovf out)
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_d;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  logic             load_c;
  logic             shift_c;
  logic             finish_c;
  logic             s_c;
  logic             co_c;

  // Full-adder bit slice on the current LSBs and the carry flop
  assign s_c  = a_sr[0] ^ b_sr[0] ^ carry;
  assign co_c = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next-state logic; start is only honoured outside RUN
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = bus.start ? RUN : IDLE;
      RUN:     state_d = (cnt == CW'(WIDTH - 1)) ? DONE : RUN;
      DONE:    state_d = bus.start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath controls decoded from the current state
  always_comb begin
    load_c   = 1'b0;
    shift_c  = 1'b0;
    finish_c = 1'b0;
    case (state)
      IDLE, DONE: load_c = bus.start;
      RUN: begin
        shift_c  = 1'b1;
        finish_c = (cnt == CW'(WIDTH - 1));
      end
      default: ;
    endcase
  end

  // Operand/result shift registers, carry flop, counter and held results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (load_c) begin
      a_sr   <= bus.a;
      b_sr   <= bus.b;
      res_sr <= '0;
      carry  <= bus.cin;
      cnt    <= '0;
    end else if (shift_c) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= {s_c, res_sr[WIDTH-1:1]};
      carry  <= co_c;
      cnt    <= cnt + CW'(1);
      if (finish_c) begin
        sum_q  <= {s_c, res_sr[WIDTH-1:1]};
        cout_q <= co_c;
        // carry flop holds the carry into the MSB on the last slice
        ovf_q  <= carry ^ co_c;
      end
    end
  end

  // busy/done registered from the next state so they track the state exactly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (state_d == RUN);
      done_q <= (state_d == DONE);
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed corner cases,
// start held during RUN, mid-operation reset, and a long back-to-back
// random run, all checked against a plain-arithmetic reference.
module tb_serial_adder;

  localparam int unsigned WIDTH = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(WIDTH)) bus ();

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] exp_sum  = '0;
  logic             exp_cout = 1'b0;
  logic             exp_ovf  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {cout,sum} = a+b+cin; signed overflow when equal-sign operands give a differing-sign sum
  task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic ci);
    logic [WIDTH:0] t;
    t        = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(ci);
    exp_sum  = t[WIDTH-1:0];
    exp_cout = t[WIDTH];
    exp_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (t[WIDTH-1] != a[WIDTH-1]);
  endtask

  task automatic chk_held(input string tag);
    chk({tag, "_sum"},  32'(bus.sum),  32'(exp_sum));
    chk({tag, "_cout"}, 32'(bus.cout), 32'(exp_cout));
    chk({tag, "_ovf"},  32'(bus.ovf),  32'(exp_ovf));
  endtask

  // Called just after a negedge; start is accepted on the following posedge.
  // Returns at the negedge of the DONE cycle with start still as last driven.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic ci, input bit hold);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = ci;
    for (int k = 1; k <= int'(WIDTH); k++) begin
      @(negedge clk);
      bus.start = hold;
      bus.a     = WIDTH'($urandom);
      bus.b     = WIDTH'($urandom);
      bus.cin   = 1'($urandom);
      chk("busy_run", 32'(bus.busy), 32'd1);
      chk("done_run", 32'(bus.done), 32'd0);
      chk_held("hold_run");
    end
    @(negedge clk);
    model(a, b, ci);
    chk("done_pulse", 32'(bus.done), 32'd1);
    chk("busy_done",  32'(bus.busy), 32'd0);
    chk_held("result");
  endtask

  task automatic idle_check(input int n);
    bus.start = 1'b0;
    repeat (n) begin
      @(negedge clk);
      chk("busy_idle", 32'(bus.busy), 32'd0);
      chk("done_idle", 32'(bus.done), 32'd0);
      chk_held("hold_idle");
    end
  endtask

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk_held("rst");
    rst = 1'b0;
    idle_check(2);

    // 0x0F + 0x01
    run_op(8'h0F, 8'h01, 1'b0, 1'b0);
    chk("s1_sum", 32'(bus.sum), 32'h10);
    idle_check(2);

    // Carry-out wrap, then signed overflow back-to-back
    run_op(8'hFF, 8'h00, 1'b1, 1'b0);
    chk("s2_sum",  32'(bus.sum),  32'h00);
    chk("s2_cout", 32'(bus.cout), 32'd1);
    run_op(8'h7F, 8'h01, 1'b0, 1'b0);
    chk("s3_sum", 32'(bus.sum), 32'h80);
    chk("s3_ovf", 32'(bus.ovf), 32'd1);
    idle_check(1);

    // Negative overflow with carry-out
    run_op(8'h80, 8'h80, 1'b0, 1'b0);
    chk("s4_cout", 32'(bus.cout), 32'd1);
    chk("s4_ovf",  32'(bus.ovf),  32'd1);
    idle_check(1);

    // start held high with changing operands during RUN
    run_op(8'h3C, 8'h5A, 1'b1, 1'b1);
    chk("s5_sum", 32'(bus.sum), 32'h97);
    idle_check(3);

    // Reset three cycles into RUN
    bus.start = 1'b1;
    bus.a     = 8'hAA;
    bus.b     = 8'h55;
    bus.cin   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    exp_sum  = '0;
    exp_cout = 1'b0;
    exp_ovf  = 1'b0;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk_held("midrst");
    @(negedge clk);
    rst = 1'b0;
    idle_check(12);
    run_op(8'h01, 8'h02, 1'b0, 1'b0);
    chk("s6_sum", 32'(bus.sum), 32'h03);
    idle_check(1);

    // Back-to-back random run with occasional start held through RUN
    run_op(8'h00, 8'h00, 1'b0, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b1, 1'b0);
    run_op(8'h80, 8'h7F, 1'b1, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));
    end
    idle_check(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
